// File: rtl/demux_pkg.sv
// demux_pkg: definitions shared by the registered demux and its mux successor.
//   MODO_SEL_EXT  : destination comes from the external selector input.
//   MODO_SEL_DATO : destination comes from the top SEL_W bits of the data word.
//   sel_width()   : width of a channel index for a given channel count.
package demux_pkg;

  localparam int MODO_SEL_EXT  = 0;
  localparam int MODO_SEL_DATO = 1;

  function automatic int sel_width(input int num_ch);
    return $clog2(num_ch);
  endfunction

endpackage

// File: rtl/demux_reg_n_if.sv
// demux_reg_n_if: input word handshake plus per-channel output bus.
//   entrada_valid/entrada_ready : valid/ready pair. A word transfers on a
//     rising edge where both are 1. ready may depend combinationally on
//     valid-side signals (selector, data MSBs), never the other way round;
//     the producer holds valid and data stable until the transfer happens.
//   entrada_dmux, selector_dmux : word and destination channel.
//   pausa        : per-channel downstream stall.
//   salida_dmux  : flattened channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH].
//   salida_valid : channel i holds a word; consumed on any edge with enb=1, pausa[i]=0.
//   error_sel    : one-cycle pulse after a word was dropped for a bad destination.
interface demux_reg_n_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4
);
  import demux_pkg::*;

  localparam int SEL_W = sel_width(NUM_CH);

  logic                         entrada_valid;
  logic [DATA_WIDTH-1:0]        entrada_dmux;
  logic [SEL_W-1:0]             selector_dmux;
  logic                         entrada_ready;
  logic [NUM_CH-1:0]            pausa;
  logic [NUM_CH*DATA_WIDTH-1:0] salida_dmux;
  logic [NUM_CH-1:0]            salida_valid;
  logic                         error_sel;

  // Demux side.
  modport slave (
    input  entrada_valid, entrada_dmux, selector_dmux, pausa,
    output entrada_ready, salida_dmux, salida_valid, error_sel
  );

  // Producer/consumer side.
  modport master (
    output entrada_valid, entrada_dmux, selector_dmux, pausa,
    input  entrada_ready, salida_dmux, salida_valid, error_sel
  );

endinterface

// File: rtl/demux_canal.sv
// demux_canal: one-entry holding register for a single demux output channel.
//   we    : write a new word (takes priority over drain, so a same-cycle
//           write and drain replaces the word and keeps valid set).
//   din   : word to write.
//   drain : downstream consumed the held word this cycle.
//   valid : register holds a word.
//   dout  : held word; keeps its last value after draining.
module demux_canal #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  drain,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dout
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (we) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/demux_reg_n.sv
// demux_reg_n: registered 1-to-NUM_CH demultiplexer with per-channel
// backpressure. Each channel is a one-entry register (demux_canal).
//   clk     : rising-edge clock.
//   reset_L : synchronous active-low reset.
//   enb     : global enable; while low nothing is accepted or drained.
//   bus     : demux_reg_n_if.slave (handshake, channel outputs, error pulse).
// MODO_SEL selects where the destination comes from (see demux_pkg).
module demux_reg_n
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int MODO_SEL   = MODO_SEL_EXT
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          enb,
  demux_reg_n_if.slave  bus
);

  localparam int SEL_W = sel_width(NUM_CH);
  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

  logic [SEL_W-1:0]      sel;
  logic                  sel_in_range;
  logic [NUM_CH-1:0]     sel_hit;
  logic [NUM_CH-1:0]     valid_vec;
  logic [NUM_CH-1:0]     we_vec;
  logic [NUM_CH-1:0]     drain_vec;
  logic [DATA_WIDTH-1:0] dout_arr [NUM_CH];
  logic                  stall;
  logic                  ready;
  logic                  accept;
  logic                  error_sel_q, error_sel_d;

  // The whole word is forwarded, including any bits used as the destination.
  always_comb begin
    sel = (MODO_SEL == MODO_SEL_DATO) ? bus.entrada_dmux[DATA_WIDTH-1 -: SEL_W]
                                      : bus.selector_dmux;
  end

  // Out-of-range indices only exist when NUM_CH is not a power of two.
  assign sel_in_range = ({1'b0, sel} < NUM_CH_W);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_hit
    assign sel_hit[i] = sel_in_range & (sel == SEL_W'(i));
  end

  // The target is blocked only if it is full and cannot drain this cycle;
  // a full channel that drains can take the new word in the same cycle.
  // Reducing over the one-hot hit vector avoids indexing with an
  // out-of-range sel; a dropped word never stalls.
  assign stall  = |(sel_hit & valid_vec & bus.pausa);
  assign ready  = reset_L & enb & ~stall;
  assign accept = bus.entrada_valid & ready;

  assign we_vec    = accept ? sel_hit : '0;
  assign drain_vec = {NUM_CH{enb}} & valid_vec & ~bus.pausa;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_canal
    demux_canal #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_canal (
      .clk     (clk),
      .reset_L (reset_L),
      .we      (we_vec[i]),
      .din     (bus.entrada_dmux),
      .drain   (drain_vec[i]),
      .valid   (valid_vec[i]),
      .dout    (dout_arr[i])
    );
  end

  // Pulse for one cycle after a dropped word; accept is already 0 when
  // enb is low, so the pulse returns to 0 while disabled.
  assign error_sel_d = accept & ~sel_in_range;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      error_sel_q <= 1'b0;
    end else begin
      error_sel_q <= error_sel_d;
    end
  end

  always_comb begin
    bus.salida_dmux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.salida_dmux[i*DATA_WIDTH +: DATA_WIDTH] = dout_arr[i];
    end
  end

  assign bus.entrada_ready = ready;
  assign bus.salida_valid  = valid_vec;
  assign bus.error_sel     = error_sel_q;

endmodule

// File: tb/tb_demux_reg_n.sv
// tb_demux_reg_n: directed bench for demux_reg_n.
//   u_dut4: NUM_CH=4, external selector.
//   u_dut3: NUM_CH=3, destination from the word MSBs (has an invalid index).
module tb_demux_reg_n;
  import demux_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_L;
  logic enb;

  always #5 clk = ~clk;

  demux_reg_n_if #(.DATA_WIDTH(8), .NUM_CH(4)) b4 ();
  demux_reg_n_if #(.DATA_WIDTH(8), .NUM_CH(3)) b3 ();

  demux_reg_n #(.DATA_WIDTH(8), .NUM_CH(4), .MODO_SEL(MODO_SEL_EXT)) u_dut4 (
    .clk     (clk),
    .reset_L (reset_L),
    .enb     (enb),
    .bus     (b4)
  );

  demux_reg_n #(.DATA_WIDTH(8), .NUM_CH(3), .MODO_SEL(MODO_SEL_DATO)) u_dut3 (
    .clk     (clk),
    .reset_L (reset_L),
    .enb     (enb),
    .bus     (b3)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [7:0] d, input logic [1:0] s);
    b4.entrada_valid = v;
    b4.entrada_dmux  = d;
    b4.selector_dmux = s;
    #1;
  endtask

  task automatic drive3(input logic v, input logic [7:0] d);
    b3.entrada_valid = v;
    b3.entrada_dmux  = d;
    b3.selector_dmux = 2'd0;
    #1;
  endtask

  logic [7:0] rr_data [4];

  initial begin
    rr_data[0] = 8'h10; rr_data[1] = 8'h21; rr_data[2] = 8'h32; rr_data[3] = 8'h43;

    reset_L = 1'b0;
    enb     = 1'b1;
    b4.pausa = 4'b0000;
    b3.pausa = 3'b000;
    drive4(1'b1, 8'hFF, 2'd0);
    drive3(1'b0, 8'h00);
    step();
    step();

    // ---- reset state ----
    check("rst_ready", {31'd0, b4.entrada_ready}, 32'd0);
    check("rst_valid", {28'd0, b4.salida_valid}, 32'd0);
    check("rst_data",  b4.salida_dmux, 32'd0);
    check("rst_err3",  {31'd0, b3.error_sel}, 32'd0);

    // ---- reset mid-stream ----
    reset_L = 1'b1;
    drive4(1'b1, 8'hA5, 2'd2);
    check("mid_ready", {31'd0, b4.entrada_ready}, 32'd1);
    step();
    drive4(1'b0, 8'h00, 2'd0);
    check("mid_valid", {28'd0, b4.salida_valid}, 32'h4);
    check("mid_data2", {24'd0, b4.salida_dmux[23:16]}, 32'hA5);
    reset_L = 1'b0;
    drive4(1'b1, 8'h55, 2'd2);
    check("mid_rst_ready", {31'd0, b4.entrada_ready}, 32'd0);
    step();
    check("mid_rst_valid", {28'd0, b4.salida_valid}, 32'd0);
    check("mid_rst_data",  b4.salida_dmux, 32'd0);
    reset_L = 1'b1;
    drive4(1'b0, 8'h00, 2'd0);
    step();

    // ---- round-robin streaming ----
    for (int k = 0; k < 4; k++) begin
      drive4(1'b1, rr_data[k], 2'(k));
      check($sformatf("rr_ready%0d", k), {31'd0, b4.entrada_ready}, 32'd1);
      step();
      check($sformatf("rr_valid%0d", k), {28'd0, b4.salida_valid}, 32'(1 << k));
      check($sformatf("rr_data%0d", k), {24'd0, b4.salida_dmux[k*8 +: 8]}, {24'd0, rr_data[k]});
    end
    drive4(1'b0, 8'h00, 2'd0);
    step();
    check("rr_drained", {28'd0, b4.salida_valid}, 32'd0);
    check("rr_hold",    b4.salida_dmux, 32'h43322110);

    // ---- sustained throughput to one channel ----
    for (int k = 0; k < 3; k++) begin
      drive4(1'b1, 8'hE0 + 8'(k), 2'd2);
      check($sformatf("tp_ready%0d", k), {31'd0, b4.entrada_ready}, 32'd1);
      step();
      check($sformatf("tp_valid%0d", k), {28'd0, b4.salida_valid}, 32'h4);
      check($sformatf("tp_data%0d", k), {24'd0, b4.salida_dmux[23:16]}, {24'd0, 8'hE0 + 8'(k)});
    end
    drive4(1'b0, 8'h00, 2'd0);
    step();

    // ---- backpressure ----
    b4.pausa = 4'b0010;
    drive4(1'b1, 8'h11, 2'd1);
    check("bp_ready_first", {31'd0, b4.entrada_ready}, 32'd1);
    step();
    drive4(1'b1, 8'h12, 2'd1);
    check("bp_ready_blocked", {31'd0, b4.entrada_ready}, 32'd0);
    step();
    check("bp_valid_hold", {28'd0, b4.salida_valid}, 32'h2);
    check("bp_data_hold",  {24'd0, b4.salida_dmux[15:8]}, 32'h11);
    drive4(1'b1, 8'h33, 2'd3);
    check("bp_ready_ch3", {31'd0, b4.entrada_ready}, 32'd1);
    step();
    check("bp_valid_ch3", {28'd0, b4.salida_valid}, 32'hA);
    check("bp_data_ch3",  {24'd0, b4.salida_dmux[31:24]}, 32'h33);
    b4.pausa = 4'b0000;
    drive4(1'b1, 8'h12, 2'd1);
    check("bp_ready_release", {31'd0, b4.entrada_ready}, 32'd1);
    step();
    check("bp_valid_swap", {28'd0, b4.salida_valid}, 32'h2);
    check("bp_data_swap",  {24'd0, b4.salida_dmux[15:8]}, 32'h12);
    drive4(1'b0, 8'h00, 2'd0);
    step();
    check("bp_empty", {28'd0, b4.salida_valid}, 32'd0);

    // ---- enable low ----
    drive4(1'b1, 8'h5A, 2'd0);
    step();
    check("enb_loaded", {28'd0, b4.salida_valid}, 32'h1);
    enb = 1'b0;
    drive4(1'b1, 8'h77, 2'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("enb_ready%0d", k), {31'd0, b4.entrada_ready}, 32'd0);
      step();
      check($sformatf("enb_valid%0d", k), {28'd0, b4.salida_valid}, 32'h1);
      check($sformatf("enb_data%0d", k), {24'd0, b4.salida_dmux[7:0]}, 32'h5A);
    end
    enb = 1'b1;
    drive4(1'b0, 8'h00, 2'd0);
    step();
    check("enb_drained", {28'd0, b4.salida_valid}, 32'd0);
    check("enb_data_kept", {24'd0, b4.salida_dmux[7:0]}, 32'h5A);

    // ---- out-of-range destination (NUM_CH=3, sel from MSBs) ----
    b3.pausa = 3'b010;
    drive3(1'b1, 8'h45);             // MSBs 01 -> channel 1, held by pausa
    check("oor_ready_ch1", {31'd0, b3.entrada_ready}, 32'd1);
    step();
    check("oor_valid_ch1", {29'd0, b3.salida_valid}, 32'h2);
    check("oor_err_inrange", {31'd0, b3.error_sel}, 32'd0);
    drive3(1'b1, 8'hC7);             // MSBs 11 -> no such channel
    check("oor_ready", {31'd0, b3.entrada_ready}, 32'd1);
    step();
    drive3(1'b0, 8'h00);
    check("oor_err_pulse", {31'd0, b3.error_sel}, 32'd1);
    check("oor_valid_same", {29'd0, b3.salida_valid}, 32'h2);
    check("oor_data_same", {8'd0, b3.salida_dmux}, 32'h004500);
    step();
    check("oor_err_clear", {31'd0, b3.error_sel}, 32'd0);
    b3.pausa = 3'b000;
    drive3(1'b1, 8'h85);             // MSBs 10 -> channel 2
    step();
    drive3(1'b0, 8'h00);
    check("oor_ch2_valid", {29'd0, b3.salida_valid}, 32'h4);
    check("oor_ch2_data", {24'd0, b3.salida_dmux[23:16]}, 32'h85);
    check("oor_ch2_err", {31'd0, b3.error_sel}, 32'd0);

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
